seq_div: RTL and testbench



---
 rtl/seq_div_pkg.sv | 18 +
 rtl/seq_div_if.sv | 24 ++
 rtl/seq_div_step.sv | 19 +
 rtl/seq_div.sv | 121 ++++++++++++
 tb/tb_seq_div.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/seq_div_pkg.sv
// Shared encodings for the sequential restoring divider.
package seq_div_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // Outcome of an operation, decided when the operands are captured.
    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_ZERO = 2'd1,
        ERR_OVF  = 2'd2
    } err_t;

endpackage

// File: rtl/seq_div_if.sv
// Request/result bundle between the demo FSM and the divider.
interface seq_div_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 div_by_zero;
    logic                 overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   r_next,
    output logic             q_bit
);
    logic [WIDTH:0] t;

    assign t = {r[WIDTH-1:0], q_msb};
    // r stays below the divisor, so r[WIDTH] is normally 0; if it were set
    // the shifted value would certainly exceed the divisor.
    assign q_bit  = r[WIDTH] | (t >= {1'b0, divisor});
    assign r_next = q_bit ? (t - {1'b0, divisor}) : t;
endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: 2*WIDTH / WIDTH -> WIDTH quotient and
// remainder, one quotient bit per clock, start/busy/done handshake.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic     clk12MHz,
    input  logic     resetn,
    seq_div_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_next;
    err_t             err;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   r_next;
    logic             q_bit;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    logic             busy, done, div_by_zero, overflow;
    logic [WIDTH-1:0] quotient, remainder;

    assign hi = bus.dividend[2*WIDTH-1:WIDTH];
    assign lo = bus.dividend[WIDTH-1:0];

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.quotient    = quotient;
    assign bus.remainder   = remainder;
    assign bus.div_by_zero = div_by_zero;
    assign bus.overflow    = overflow;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r       (r),
        .q_msb   (q[WIDTH-1]),
        .divisor (d),
        .r_next  (r_next),
        .q_bit   (q_bit)
    );

    // State register.
    always_ff @(posedge clk12MHz or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    // Next state: errors are detected up front and skip the iterations.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0 || hi >= bus.divisor) state_next = S_FIN;
                    else                                        state_next = S_CALC;
                end
            end
            S_CALC:  if (cnt == CW'(1)) state_next = S_FIN;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath and result registers; results only move on the FIN edge.
    always_ff @(posedge clk12MHz or negedge resetn) begin
        if (!resetn) begin
            err         <= ERR_NONE;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        r    <= {1'b0, hi};
                        q    <= lo;
                        d    <= bus.divisor;
                        cnt  <= CW'(WIDTH);
                        busy <= 1'b1;
                        if (bus.divisor == '0)      err <= ERR_ZERO;
                        else if (hi >= bus.divisor) err <= ERR_OVF;
                        else                        err <= ERR_NONE;
                    end
                end
                S_CALC: begin
                    r   <= r_next;
                    q   <= {q[WIDTH-2:0], q_bit};
                    cnt <= cnt - CW'(1);
                end
                S_FIN: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    if (err == ERR_NONE) begin
                        quotient    <= q;
                        remainder   <= r[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end else begin
                        quotient    <= '1;
                        remainder   <= '0;
                        div_by_zero <= (err == ERR_ZERO);
                        overflow    <= (err == ERR_OVF);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_div.sv
// Randomized scoreboard bench for seq_div (WIDTH=8).
module tb_seq_div;
    localparam int W = 8;

    typedef struct {
        int unsigned issue;
        int unsigned lat;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        logic         o;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [W-1:0] hq = '0, hr = '0;
    logic hz = 1'b0, ho = 1'b0;

    seq_div_if #(.WIDTH(W)) bus ();

    seq_div #(.WIDTH(W)) dut (
        .clk12MHz (clk),
        .resetn   (resetn),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference: plain integer division plus the documented error rules.
    function automatic exp_t model(input int unsigned dvd, input int unsigned dvs);
        exp_t e;
        e.issue = 0;
        if (dvs == 0) begin
            e.q = '1; e.r = '0; e.z = 1'b1; e.o = 1'b0; e.lat = 2;
        end else if (dvd / dvs > 255) begin
            e.q = '1; e.r = '0; e.z = 1'b0; e.o = 1'b1; e.lat = 2;
        end else begin
            e.q = 8'(dvd / dvs); e.r = 8'(dvd % dvs); e.z = 1'b0; e.o = 1'b0; e.lat = W + 2;
        end
        return e;
    endfunction

    // Monitor: per-cycle busy/done timing and held-result checks.
    always @(negedge clk) begin
        logic exp_done, exp_busy;
        int unsigned age;
        exp_done = 1'b0;
        exp_busy = 1'b0;
        if (!resetn) begin
            sb.delete();
            hq = '0; hr = '0; hz = 1'b0; ho = 1'b0;
        end else if (sb.size() > 0 && cyc > sb[0].issue) begin
            age = cyc - sb[0].issue;
            exp_done = (age == sb[0].lat);
            exp_busy = (age < sb[0].lat);
        end
        check("busy", 32'(bus.busy), 32'(exp_busy));
        check("done", 32'(bus.done), 32'(exp_done));
        if (exp_done) begin
            hq = sb[0].q; hr = sb[0].r; hz = sb[0].z; ho = sb[0].o;
            sb.pop_front();
        end
        check("quotient", 32'(bus.quotient), 32'(hq));
        check("remainder", 32'(bus.remainder), 32'(hr));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(hz));
        check("overflow", 32'(bus.overflow), 32'(ho));
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.busy) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy still %0d after %0d cycles", bus.busy, n);
        end
    endtask

    // Drive a start for one cycle (caller is one time step after an edge, busy=0).
    task automatic issue(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        exp_t e;
        bus.start = 1'b1; bus.dividend = dvd; bus.divisor = dvs;
        e = model(32'(dvd), 32'(dvs));
        e.issue = cyc;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor = 8'($urandom);
    endtask

    task automatic do_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        wait_idle();
        issue(dvd, dvs);
    endtask

    initial begin
        int n;
        logic [W-1:0] b, hi;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_quotient", 32'(bus.quotient), 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        do_op(16'd12345, 8'd100);
        do_op(16'hFE01, 8'hFF);
        for (int a = 0; a < 256; a++) begin
            b = 8'($urandom_range(1, 255));
            do_op(16'(a * b), b);
        end
        do_op(16'h1234, 8'd0);
        do_op(16'h0500, 8'd5);
        do_op(16'd100, 8'd7);

        // Reset in the middle of the iterations: everything clears at once.
        do_op(16'd1000, 8'd9);
        repeat (3) begin @(posedge clk); #1; end
        resetn = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_done", 32'(bus.done), 0);
        check("midrst_quotient", 32'(bus.quotient), 0);
        check("midrst_remainder", 32'(bus.remainder), 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        do_op(16'd1000, 8'd9);

        // Back-to-back: start during the done cycle, then a start while busy.
        do_op(16'd77, 8'd7);
        n = 0;
        while (!bus.done && n < 40) begin @(posedge clk); #1; n++; end
        check("b2b_done_seen", 32'(bus.done), 1);
        check("b2b_busy_low", 32'(bus.busy), 0);
        issue(16'd50, 8'd6);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.dividend = 16'($urandom); bus.divisor = 8'($urandom);
        @(posedge clk); #1;
        bus.start = 1'b0;

        // Random mix of valid, overflow and zero-divisor operations.
        for (int i = 0; i < 200; i++) begin
            n = int'($urandom_range(0, 9));
            if (n == 0) begin
                do_op(16'($urandom), 8'd0);
            end else if (n < 3) begin
                do_op(16'($urandom), 8'($urandom));
            end else begin
                b = 8'($urandom_range(1, 255));
                hi = 8'($urandom_range(0, int'(b) - 1));
                do_op({hi, 8'($urandom)}, b);
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end

        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
